// File: rtl/psola_pkg.sv
// Shared types, sizing constants and the shift/saturate helper for PSOLA playback.
package psola_pkg;

   localparam int DEF_WINDOW_SIZE = 2048;
   localparam int DEF_OUT_WIDTH   = 16;
   localparam int FRAME_DEPTH     = 2 * DEF_WINDOW_SIZE;
   localparam int LEN_WIDTH       = $clog2(FRAME_DEPTH) + 1;

   typedef logic signed [31:0]              sample_t;
   typedef logic signed [DEF_OUT_WIDTH-1:0] out_sample_t;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PLAY = 1'b1;

   // Arithmetic shift then clamp into the default output width.
   function automatic out_sample_t sat_shift(input sample_t s, input int unsigned shift);
      sample_t v;
      sample_t max_v;
      sample_t min_v;
      v     = s >>> shift;
      max_v = sample_t'((1 << (DEF_OUT_WIDTH - 1)) - 1);
      min_v = -max_v - 32'sd1;
      if (v > max_v)      return max_v[DEF_OUT_WIDTH-1:0];
      else if (v < min_v) return min_v[DEF_OUT_WIDTH-1:0];
      else                return v[DEF_OUT_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/psola_playback_sample_saturator.sv
// Combinational conversion of a 32-bit accumulator sample to a DAC-width sample.
module sample_saturator
   import psola_pkg::*;
#(
   parameter int OUT_WIDTH = DEF_OUT_WIDTH,
   parameter int SHIFT     = 8
) (
   input  sample_t                      din_i,
   output logic signed [OUT_WIDTH-1:0]  dout_o
);

   localparam sample_t MAX_V = sample_t'((1 << (OUT_WIDTH - 1)) - 1);
   localparam sample_t MIN_V = -MAX_V - 32'sd1;

   sample_t shifted;

   // Shift, then clamp to the signed output range.
   always_comb begin
      shifted = din_i >>> SHIFT;
      if (shifted > MAX_V)      dout_o = MAX_V[OUT_WIDTH-1:0];
      else if (shifted < MIN_V) dout_o = MIN_V[OUT_WIDTH-1:0];
      else                      dout_o = shifted[OUT_WIDTH-1:0];
   end

endmodule

// File: rtl/psola_playback.sv
// Double-buffered frame capture and tick-paced playback of PSOLA output frames.
//   state   | meaning
//   IDLE    | nothing playing; swaps in a pending frame, or flags underrun on tick
//   PLAY    | emitting one sample per tick from the play bank
module psola_playback
   import psola_pkg::*;
#(
   parameter int WINDOW_SIZE = DEF_WINDOW_SIZE,
   parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
   parameter int SHIFT       = 8,
   localparam int DEPTH      = 2 * WINDOW_SIZE,
   localparam int LW         = $clog2(DEPTH) + 1
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  sample_t                      frame_in [DEPTH],
   input  logic [LW-1:0]                frame_len_in,
   input  logic                         frame_valid_in,
   input  logic                         sample_tick_in,
   output logic signed [OUT_WIDTH-1:0]  sample_out,
   output logic                         sample_valid_out,
   output logic                         playing_out,
   output logic                         underrun_out,
   output logic [15:0]                  drop_count_out
);

   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   sample_t                     bank_q [2][DEPTH];
   logic [LW-1:0]               len_q  [2];

   logic [0:0]                  state_q, state_d;
   logic                        sel_q, sel_d;
   logic                        pend_q, pend_d;
   logic [LW-2:0]               idx_q, idx_d;
   logic signed [OUT_WIDTH-1:0] sample_q, sample_d;
   logic                        valid_q, valid_d;
   logic                        underrun_q, underrun_d;
   logic [15:0]                 drop_q, drop_d;

   logic                        swap, cap, cap_bank, last;
   logic [LW-1:0]               len_c;
   logic signed [OUT_WIDTH-1:0] sat_val;

   sample_saturator #(.OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT)) u_sat (
      .din_i  (bank_q[sel_q][idx_q]),
      .dout_o (sat_val)
   );

   // Next-state logic for playback FSM, bank roles, capture and drop counting.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      pend_d     = pend_q;
      idx_d      = idx_q;
      sample_d   = sample_q;
      valid_d    = 1'b0;
      underrun_d = underrun_q;
      drop_d     = drop_q;
      swap       = 1'b0;
      last       = ({1'b0, idx_q} == (len_q[sel_q] - 1'b1));
      len_c      = (frame_len_in > DEPTH_L) ? DEPTH_L : frame_len_in;
      cap        = frame_valid_in && (frame_len_in != '0);

      case (state_q)
         ST_IDLE: begin
            if (pend_q) begin
               swap    = 1'b1;
               idx_d   = '0;
               state_d = ST_PLAY;
            end else if (sample_tick_in) begin
               underrun_d = 1'b1;
               sample_d   = '0;
               valid_d    = 1'b1;
            end
         end
         default: begin
            if (sample_tick_in) begin
               sample_d = sat_val;
               valid_d  = 1'b1;
               if (last) begin
                  idx_d = '0;
                  if (pend_q) swap    = 1'b1;
                  else        state_d = ST_IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
      endcase

      if (swap) begin
         sel_d  = ~sel_q;
         pend_d = 1'b0;
      end

      // A frame arriving on a swap cycle lands in the bank just freed, so no drop.
      if (cap) begin
         pend_d = 1'b1;
         if (pend_q && !swap && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
      end
      cap_bank = ~sel_d;
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= ST_IDLE;
         sel_q      <= 1'b0;
         pend_q     <= 1'b0;
         idx_q      <= '0;
         sample_q   <= '0;
         valid_q    <= 1'b0;
         underrun_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         pend_q     <= pend_d;
         idx_q      <= idx_d;
         sample_q   <= sample_d;
         valid_q    <= valid_d;
         underrun_q <= underrun_d;
         drop_q     <= drop_d;
      end
   end

   // Frame storage; contents only matter once pend_q marks them valid.
   always_ff @(posedge clk_in) begin
      if (!rst_in && cap) begin
         len_q[cap_bank] <= len_c;
         for (int i = 0; i < DEPTH; i++) bank_q[cap_bank][i] <= frame_in[i];
      end
   end

   assign sample_out       = sample_q;
   assign sample_valid_out = valid_q;
   assign playing_out      = (state_q == ST_PLAY);
   assign underrun_out     = underrun_q;
   assign drop_count_out   = drop_q;

endmodule

// File: tb/tb_psola_playback.sv
// Directed self-checking bench for psola_playback (WINDOW_SIZE=2, depth 4).
module tb_psola_playback;
   import psola_pkg::*;

   localparam int WS = 2;
   localparam int D  = 2 * WS;
   localparam int LW = $clog2(D) + 1;

   logic                clk_in = 1'b0;
   logic                rst_in = 1'b0;
   sample_t             frame_in [D];
   logic [LW-1:0]       frame_len_in = '0;
   logic                frame_valid_in = 1'b0;
   logic                sample_tick_in = 1'b0;
   logic signed [15:0]  sample_out;
   logic                sample_valid_out;
   logic                playing_out;
   logic                underrun_out;
   logic [15:0]         drop_count_out;

   int tests = 0;
   int fails = 0;

   always #5 clk_in = ~clk_in;

   psola_playback #(.WINDOW_SIZE(WS), .OUT_WIDTH(16), .SHIFT(8)) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .frame_in         (frame_in),
      .frame_len_in     (frame_len_in),
      .frame_valid_in   (frame_valid_in),
      .sample_tick_in   (sample_tick_in),
      .sample_out       (sample_out),
      .sample_valid_out (sample_valid_out),
      .playing_out      (playing_out),
      .underrun_out     (underrun_out),
      .drop_count_out   (drop_count_out)
   );

   task automatic step;
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_frame(input int len, input sample_t a, input sample_t b,
                            input sample_t c, input sample_t d);
      frame_in[0]  = a;
      frame_in[1]  = b;
      frame_in[2]  = c;
      frame_in[3]  = d;
      frame_len_in = LW'(len);
   endtask

   task automatic load(input int len, input sample_t a, input sample_t b,
                       input sample_t c, input sample_t d);
      set_frame(len, a, b, c, d);
      frame_valid_in = 1'b1;
      step();
      frame_valid_in = 1'b0;
   endtask

   task automatic tick_chk(input string tag, input int exp);
      sample_tick_in = 1'b1;
      step();
      sample_tick_in = 1'b0;
      chk({tag, "_valid"}, 32'(sample_valid_out), 1);
      chk(tag, 32'(sample_out), exp);
   endtask

   task automatic do_reset;
      rst_in = 1'b1;
      step();
      step();
      rst_in = 1'b0;
   endtask

   initial begin
      set_frame(0, 0, 0, 0, 0);

      // Reset state, then underrun ticks
      do_reset();
      chk("rst_sample",   32'(sample_out), 0);
      chk("rst_valid",    32'(sample_valid_out), 0);
      chk("rst_playing",  32'(playing_out), 0);
      chk("rst_underrun", 32'(underrun_out), 0);
      chk("rst_drop",     32'(drop_count_out), 0);
      tick_chk("ur0", 0);
      tick_chk("ur1", 0);
      tick_chk("ur2", 0);
      chk("ur_flag", 32'(underrun_out), 1);
      chk("ur_playing", 32'(playing_out), 0);
      step();
      chk("valid_drops", 32'(sample_valid_out), 0);

      // Basic frame of 4 with shift
      do_reset();
      load(4, 256, -512, 1024, 0);
      chk("pre_swap_playing", 32'(playing_out), 0);
      step();
      chk("post_swap_playing", 32'(playing_out), 1);
      chk("swap_no_valid", 32'(sample_valid_out), 0);
      tick_chk("f0", 1);
      tick_chk("f1", -2);
      tick_chk("f2", 4);
      chk("f2_playing", 32'(playing_out), 1);
      tick_chk("f3", 0);
      chk("f3_playing", 32'(playing_out), 0);
      chk("f3_underrun", 32'(underrun_out), 0);
      tick_chk("f4", 0);
      chk("f4_underrun", 32'(underrun_out), 1);

      // Saturation at both rails
      do_reset();
      load(2, 32'sh7FFF_FFFF, 32'sh8000_0000, 0, 0);
      step();
      tick_chk("sat_max", 32767);
      tick_chk("sat_min", -32768);

      // Gapless A(3) then B(2)
      do_reset();
      load(3, 32'sh100, 32'sh200, 32'sh300, 0);
      step();
      tick_chk("gA0", 1);
      load(2, 32'sh400, 32'sh500, 0, 0);
      tick_chk("gA1", 2);
      tick_chk("gA2", 3);
      chk("g_swap_playing", 32'(playing_out), 1);
      tick_chk("gB0", 4);
      tick_chk("gB1", 5);
      chk("g_end_playing", 32'(playing_out), 0);
      chk("g_underrun", 32'(underrun_out), 0);
      chk("g_drop", 32'(drop_count_out), 0);

      // Dropped frame: B overwritten by C
      do_reset();
      load(3, 32'sh100, 32'sh200, 32'sh300, 0);
      step();
      load(1, 32'sh700, 0, 0, 0);
      chk("d_drop0", 32'(drop_count_out), 0);
      load(2, 32'sh900, 32'shA00, 0, 0);
      chk("d_drop1", 32'(drop_count_out), 1);
      tick_chk("dA0", 1);
      tick_chk("dA1", 2);
      tick_chk("dA2", 3);
      tick_chk("dC0", 9);
      tick_chk("dC1", 10);
      chk("d_end_playing", 32'(playing_out), 0);
      chk("d_underrun", 32'(underrun_out), 0);

      // Capture on the same cycle as a gapless swap: no drop, C follows B
      do_reset();
      load(2, 32'sh100, 32'sh200, 0, 0);
      step();
      load(1, 32'sh300, 0, 0, 0);
      tick_chk("sA0", 1);
      set_frame(1, 32'sh500, 0, 0, 0);
      frame_valid_in = 1'b1;
      tick_chk("sA1", 2);
      frame_valid_in = 1'b0;
      chk("s_drop", 32'(drop_count_out), 0);
      tick_chk("sB0", 3);
      tick_chk("sC0", 5);
      chk("s_end_playing", 32'(playing_out), 0);
      chk("s_underrun", 32'(underrun_out), 0);

      // Zero length ignored; overlong length clamped to 4
      do_reset();
      load(0, 32'sh100, 0, 0, 0);
      step();
      chk("z_playing", 32'(playing_out), 0);
      load(7, 32'sh100, 32'sh200, 32'sh300, 32'sh400);
      step();
      chk("c_playing", 32'(playing_out), 1);
      tick_chk("c0", 1);
      tick_chk("c1", 2);
      tick_chk("c2", 3);
      tick_chk("c3", 4);
      chk("c_end_playing", 32'(playing_out), 0);
      chk("c_underrun", 32'(underrun_out), 0);

      // Reset mid-frame at idx=2
      do_reset();
      load(4, 32'sh100, 32'sh200, 32'sh300, 32'sh400);
      step();
      tick_chk("m0", 1);
      tick_chk("m1", 2);
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
      chk("m_sample",   32'(sample_out), 0);
      chk("m_valid",    32'(sample_valid_out), 0);
      chk("m_playing",  32'(playing_out), 0);
      chk("m_underrun", 32'(underrun_out), 0);
      chk("m_drop",     32'(drop_count_out), 0);
      tick_chk("m_tick", 0);
      chk("m_tick_underrun", 32'(underrun_out), 1);
      chk("m_tick_playing", 32'(playing_out), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
